iter_counter: RTL and testbench
===============================

ITER_COUNTER -- requirements
Module: iter_counter

Interface
REQ-001 Parameter: WIDTH, default 5, counter and limit width in bits (WIDTH >= 1).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  begin a counting run; samples limit.
REQ-005 Port: en  input  1  count enable; advances count only while busy.
REQ-006 Port: limit  input  WIDTH  terminal count; run covers 0..limit inclusive.
REQ-007 Port: count  output  WIDTH  current iteration index.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: last  output  1  combinational: busy and count equals latched limit.
REQ-010 Port: done  output  1  one-cycle pulse after final iteration.
REQ-011 Port (only with ITER_COUNTER_ABORT_EN): abort  input  1  cancel run without done.

Function
REQ-012 FSM SHALL have three states: IDLE, RUN, DONE; busy = (state == RUN), done = (state == DONE), both registered.
REQ-013 IDLE: start=1 -> RUN next cycle, count <= 0, limit_q <= limit; start=0 -> stay IDLE, count holds.
REQ-014 RUN, en=1, count != limit_q: count <= count + 1, stay RUN.
REQ-015 RUN, en=1, count == limit_q: -> DONE, count holds at limit_q (no wrap to 0).
REQ-016 RUN, en=0: count and state hold (stall of any length).
REQ-017 DONE: -> IDLE next cycle unless start=1, in which case -> RUN with count <= 0 and limit_q <= limit (back-to-back runs, no idle gap).
REQ-018 start=1 in RUN SHALL restart: count <= 0, limit_q <= limit, stay RUN, no done pulse; start overrides en that cycle.
REQ-019 limit SHALL be sampled only on an accepted start; changes to limit during RUN are ignored.
REQ-020 A run SHALL consume exactly limit_q+1 enabled RUN cycles; limit=0 -> DONE after first en cycle.
REQ-021 limit = 2^WIDTH-1 SHALL complete normally; count never overflows.
REQ-022 last SHALL be 0 outside RUN; with en=1 every cycle, done rises the cycle after last.
REQ-023 Priority per cycle: reset > abort (if compiled) > start > en.

Reset
REQ-024 reset=1 at a clock edge SHALL force state IDLE, count=0, limit_q=0, busy=0, done=0, last=0, regardless of state, including mid-RUN and in DONE.
REQ-025 No done pulse SHALL be generated by or after a reset that interrupts a run.
REQ-026 start asserted together with reset SHALL be ignored.

Configuration
REQ-027 Macro ITER_COUNTER_ABORT_EN: when defined, abort port exists; abort=1 in RUN or DONE -> IDLE next cycle, count <= 0, no done pulse; abort in IDLE has no effect; abort beats simultaneous start.
REQ-028 When ITER_COUNTER_ABORT_EN is undefined, the abort port SHALL not exist and behaviour is REQ-012..REQ-026 unchanged.

Verification
REQ-029 WIDTH=5, limit=31, start pulse, en=1 continuous -> count 0..31 over 32 cycles, last high on count=31, done single pulse next cycle, busy low with done.
REQ-030 WIDTH=5, limit=3, en toggled 1,0,1,0... -> count advances only on en=1 cycles, done after 4th enabled cycle, count holds 3 at done.
REQ-031 limit=0, start, en=1 -> busy one cycle with count=0 and last=1, then done pulse, then IDLE.
REQ-032 limit=10, start; at count=5 assert start with limit=2 -> count back to 0, run ends after 3 more enabled cycles, exactly one done; limit changed mid-run to 0 without start -> no effect.
REQ-033 limit=7, reset asserted at count=4 -> next cycle count=0, busy=0, done never pulses; start held with reset ignored.
REQ-034 With ITER_COUNTER_ABORT_EN: limit=7, abort at count=3 -> IDLE, count=0, no done; start in DONE cycle -> immediate new run with count=0.

Source files
------------

// File: rtl/iter_counter.sv
`default_nettype none
// ============================================================================
// Module   : iter_counter
// Purpose  : Run counter 0..limit with stall, restart and one-cycle done pulse.
//            Define ITER_COUNTER_ABORT_EN to add the abort input.
// Revision : 1.0 - initial release
// ============================================================================
module iter_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
`ifdef ITER_COUNTER_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             w_abort;
  logic             w_at_limit;

`ifdef ITER_COUNTER_ABORT_EN
  // Abort only matters once a run has been accepted.
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_at_limit = (r_count == r_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_limit <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else if (start) begin
      // Same action from every state: fresh run, new terminal count.
      r_state <= S_RUN;
      r_count <= '0;
      r_limit <= limit;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_RUN: begin
          if (en) begin
            if (w_at_limit) begin
              r_state <= S_DONE;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign count = r_count;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign last  = busy && w_at_limit;

endmodule
`default_nettype wire

// File: tb/tb_iter_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_counter
// Purpose  : Directed vector table plus multi-cycle sequences for iter_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] limit = 5'd0;
  logic [4:0] count;
  logic       busy;
  logic       last;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_counter #(.WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .en    (en),
`ifdef ITER_COUNTER_ABORT_EN
    .abort (abort),
`endif
    .limit (limit),
    .count (count),
    .busy  (busy),
    .last  (last),
    .done  (done)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic       e;
    logic [4:0] lim;
    logic [4:0] c;
    logic       b;
    logic       la;
    logic       d;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];

  function automatic vec_t mk(input int r, input int s, input int e, input int l,
                              input int c, input int b, input int la, input int d);
    vec_t v;
    v.rst = r[0]; v.st = s[0]; v.e = e[0]; v.lim = l[4:0];
    v.c = c[4:0]; v.b = b[0]; v.la = la[0]; v.d = d[0];
    return v;
  endfunction

  // Apply inputs for one clock, then settle just after the edge.
  task automatic cyc(input logic r, input logic s, input logic e, input logic [4:0] l);
    reset = r; start = s; en = e; limit = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] c, input logic b,
                     input logic la, input logic d);
    checks++;
    if (count !== c || busy !== b || last !== la || done !== d) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%b last=%b done=%b, want count=%0d busy=%b last=%b done=%b",
               name, count, busy, last, done, c, b, la, d);
    end
  endtask

  initial begin
    int ndone;
    // rst st en lim | count busy last done
    vecs[0]  = mk(1,1,0,5,  0,0,0,0);  // start with reset ignored
    vecs[1]  = mk(0,0,1,5,  0,0,0,0);
    vecs[2]  = mk(0,1,0,0,  0,1,1,0);  // limit=0 run
    vecs[3]  = mk(0,0,1,0,  0,0,0,1);
    vecs[4]  = mk(0,0,0,0,  0,0,0,0);
    vecs[5]  = mk(0,1,0,3,  0,1,0,0);  // limit=3, en toggling
    vecs[6]  = mk(0,0,1,3,  1,1,0,0);
    vecs[7]  = mk(0,0,0,3,  1,1,0,0);
    vecs[8]  = mk(0,0,1,3,  2,1,0,0);
    vecs[9]  = mk(0,0,0,3,  2,1,0,0);
    vecs[10] = mk(0,0,1,3,  3,1,1,0);
    vecs[11] = mk(0,0,0,3,  3,1,1,0);
    vecs[12] = mk(0,0,1,3,  3,0,0,1);
    vecs[13] = mk(0,0,0,3,  3,0,0,0);
    vecs[14] = mk(0,1,1,7,  0,1,0,0);  // limit=7, reset at count 4
    vecs[15] = mk(0,0,1,7,  1,1,0,0);
    vecs[16] = mk(0,0,1,7,  2,1,0,0);
    vecs[17] = mk(0,0,1,7,  3,1,0,0);
    vecs[18] = mk(0,0,1,7,  4,1,0,0);
    vecs[19] = mk(1,1,1,7,  0,0,0,0);
    vecs[20] = mk(0,0,1,7,  0,0,0,0);
    vecs[21] = mk(0,0,1,7,  0,0,0,0);
    vecs[22] = mk(0,1,1,1,  0,1,0,0);  // back-to-back runs
    vecs[23] = mk(0,0,1,1,  1,1,1,0);
    vecs[24] = mk(0,0,1,1,  1,0,0,1);
    vecs[25] = mk(0,1,1,2,  0,1,0,0);  // start in DONE
    vecs[26] = mk(0,0,1,0,  1,1,0,0);  // limit change ignored
    vecs[27] = mk(0,0,1,0,  2,1,1,0);
    vecs[28] = mk(0,0,1,0,  2,0,0,1);
    vecs[29] = mk(0,0,0,0,  2,0,0,0);
    vecs[30] = mk(0,1,0,3,  0,1,0,0);  // restart overrides en
    vecs[31] = mk(0,0,1,3,  1,1,0,0);
    vecs[32] = mk(0,1,1,1,  0,1,0,0);
    vecs[33] = mk(0,0,1,1,  1,1,1,0);
    vecs[34] = mk(0,0,1,1,  1,0,0,1);

    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    chk("reset_state", 5'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].rst, vecs[i].st, vecs[i].e, vecs[i].lim);
      chk($sformatf("vec%0d", i), vecs[i].c, vecs[i].b, vecs[i].la, vecs[i].d);
    end
    cyc(1'b0, 1'b0, 1'b0, 5'd0);

    // Full-range run: limit = 31
    cyc(1'b0, 1'b1, 1'b1, 5'd31);
    chk("full_c0", 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 31; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 5'd31);
      chk($sformatf("full_c%0d", i), 5'(i), 1'b1, (i == 31), 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1, 5'd31);
    chk("full_done", 5'd31, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 5'd31);
    chk("full_idle", 5'd31, 1'b0, 1'b0, 1'b0);

    // Restart mid-run: limit 10, restart at count 5 with limit 2
    cyc(1'b0, 1'b1, 1'b1, 5'd10);
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, 1'b1, 5'd10);
    chk("rs_at5", 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 5'd2);
    chk("rs_zero", 5'd0, 1'b1, 1'b0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 5'd0);
      if (done) ndone++;
      if (i == 1) chk("rs_last", 5'd2, 1'b1, 1'b1, 1'b0);
      if (i == 2) chk("rs_done", 5'd2, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL rs_done_count: got %0d done pulses, want 1", ndone);
    end

`ifdef ITER_COUNTER_ABORT_EN
    // Abort in IDLE is ignored
    abort = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    chk("ab_idle", 5'd2, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 5'd7);
    for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 1'b1, 5'd7);
    chk("ab_at3", 5'd3, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 5'd7);  // abort beats start
    chk("ab_run", 5'd0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 5'd7);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL ab_quiet: got %0d busy/done cycles, want 0", ndone);
    end
    // Abort in DONE
    cyc(1'b0, 1'b1, 1'b1, 5'd0);
    cyc(1'b0, 1'b0, 1'b1, 5'd0);
    chk("ab_pre_done", 5'd0, 1'b0, 1'b0, 1'b1);
    abort = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 5'd4);
    chk("ab_done", 5'd0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
`endif

    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    chk("final_reset", 5'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
